// File: rtl/axi_rd_4k_breaker.sv
// AXI read-channel stage that splits INCR bursts at 4KB boundaries and re-merges the
// returned R beats into one burst with a single rlast; one piece outstanding at a time.
module axi_rd_4k_breaker #(
    parameter int AWID   = 32,
    parameter int EXTRAS = 8,
    parameter int IDWID  = 4,
    parameter int DWID   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDWID-1:0]  arid,
    input  logic [AWID-1:0]   araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [EXTRAS-1:0] arextras,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [IDWID-1:0]  rid,
    output logic [DWID-1:0]   rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    output logic [IDWID-1:0]  o_arid,
    output logic [AWID-1:0]   o_araddr,
    output logic [7:0]        o_arlen,
    output logic [2:0]        o_arsize,
    output logic [EXTRAS-1:0] o_arextras,
    output logic [1:0]        o_arburst,
    output logic              o_arvalid,
    input  logic              o_arready,
    input  logic [IDWID-1:0]  o_rid,
    input  logic [DWID-1:0]   o_rdata,
    input  logic [1:0]        o_rresp,
    input  logic              o_rlast,
    input  logic              o_rvalid,
    output logic              o_rready
);

    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [8:0]      remaining;
    logic [AWID-1:0] next_page;
    logic [AWID-1:0] src_addr;
    logic [8:0]      src_rem;
    logic [8:0]      src_plen;
    logic [8:0]      issued_len;
    logic [2:0]      src_size;
    logic [1:0]      src_burst;
    logic            ar_hs;
    logic            last_beat;
    logic            load_piece;

    // Beats that fit before the next 4KB page; non-INCR bursts are never cut.
    function automatic logic [8:0] piece_len(input logic [11:0] addr_lo,
                                             input logic [2:0]  size,
                                             input logic [1:0]  burst,
                                             input logic [8:0]  rem);
        logic [11:0] aligned;
        logic [12:0] avail;
        aligned = addr_lo & ~((12'd1 << size) - 12'd1);
        avail   = (13'h1000 - {1'b0, aligned}) >> size;
        if (burst != BURST_INCR || {4'd0, rem} <= avail)
            return rem;
        return avail[8:0];
    endfunction

    assign next_page  = (o_araddr | AWID'(12'hFFF)) + AWID'(1);
    assign issued_len = {1'b0, o_arlen} + 9'd1;
    assign ar_hs      = arready && arvalid;
    assign last_beat  = o_rvalid && rready && o_rlast;
    assign load_piece = ar_hs || (state == DATA && last_beat && remaining != 9'd0);

    assign rid   = o_rid;
    assign rdata = o_rdata;
    assign rresp = o_rresp;

    // First piece sizes from the upstream request; later pieces start on the next page.
    always_comb begin
        src_addr  = next_page;
        src_rem   = remaining;
        src_size  = o_arsize;
        src_burst = o_arburst;
        if (state == IDLE) begin
            src_addr  = araddr;
            src_rem   = {1'b0, arlen} + 9'd1;
            src_size  = arsize;
            src_burst = arburst;
        end
        src_plen = piece_len(src_addr[11:0], src_size, src_burst, src_rem);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        arready   = 1'b0;
        o_arvalid = 1'b0;
        rvalid    = 1'b0;
        o_rready  = 1'b0;
        rlast     = 1'b0;
        case (state)
            IDLE: begin
                arready = 1'b1;
                if (arvalid)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                o_arvalid = 1'b1;
                if (o_arready)
                    state_nxt = DATA;
            end
            DATA: begin
                rvalid   = o_rvalid;
                o_rready = rready;
                rlast    = o_rlast && (remaining == 9'd0);
                if (last_beat)
                    state_nxt = (remaining != 9'd0) ? ISSUE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            arready   = 1'b0;
            o_arvalid = 1'b0;
            rvalid    = 1'b0;
            o_rready  = 1'b0;
            rlast     = 1'b0;
        end
    end

    // remaining counts beats not yet requested downstream, so it reads 0 during the final piece.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_arid     <= '0;
            o_araddr   <= '0;
            o_arlen    <= '0;
            o_arsize   <= '0;
            o_arextras <= '0;
            o_arburst  <= '0;
            remaining  <= '0;
        end else begin
            if (load_piece) begin
                o_araddr  <= src_addr;
                o_arlen   <= 8'(src_plen - 9'd1);
                remaining <= src_rem;
            end
            if (ar_hs) begin
                o_arid     <= arid;
                o_arsize   <= arsize;
                o_arburst  <= arburst;
                o_arextras <= arextras;
            end
            if (state == ISSUE && o_arready)
                remaining <= remaining - issued_len;
        end
    end

endmodule

// File: tb/tb_axi_rd_4k_breaker.sv
// Directed bench for axi_rd_4k_breaker: a behavioural splitter-side slave answers each
// piece with address-derived data so splitting, merging and ordering can all be checked.
module tb_axi_rd_4k_breaker;

    localparam int AWID   = 32;
    localparam int EXTRAS = 8;
    localparam int IDWID  = 4;
    localparam int DWID   = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [IDWID-1:0]  arid;
    logic [AWID-1:0]   araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [EXTRAS-1:0] arextras;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [IDWID-1:0]  rid;
    logic [DWID-1:0]   rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    logic [IDWID-1:0]  o_arid;
    logic [AWID-1:0]   o_araddr;
    logic [7:0]        o_arlen;
    logic [2:0]        o_arsize;
    logic [EXTRAS-1:0] o_arextras;
    logic [1:0]        o_arburst;
    logic              o_arvalid;
    logic              o_arready;
    logic [IDWID-1:0]  o_rid;
    logic [DWID-1:0]   o_rdata;
    logic [1:0]        o_rresp;
    logic              o_rlast;
    logic              o_rvalid;
    logic              o_rready;

    always #5 clk = ~clk;

    axi_rd_4k_breaker #(.AWID(AWID), .EXTRAS(EXTRAS), .IDWID(IDWID), .DWID(DWID)) dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arextras(arextras),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
        .o_arextras(o_arextras), .o_arburst(o_arburst), .o_arvalid(o_arvalid), .o_arready(o_arready),
        .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast),
        .o_rvalid(o_rvalid), .o_rready(o_rready)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Slave-side log of every downstream AR accepted
    logic [31:0] ar_log_addr[$];
    logic [7:0]  ar_log_len[$];
    logic [16:0] ar_log_misc[$];
    int          stall_cfg = 0;

    // Master-side bookkeeping
    logic [63:0] beat_q[$];
    logic [1:0]  resp_q[$];
    logic [3:0]  last_rid;
    int          rlast_cnt, rlast_idx, cyc, up_hs_cyc, first_arv_cyc, stable_err, stall_cnt, ar_base;
    bit          prev_arv_wait;
    logic [63:0] prev_pl;

    function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [2:0] size, input int k);
        logic [31:0] al;
        al = start & ~((32'd1 << size) - 32'd1);
        if (k == 0) return start;
        return al + (32'(k) << size);
    endfunction

    // Behavioural splitter: optional AR stall, then len+1 beats of address-derived data
    initial begin : slave
        int          s_beats, s_k, stall_left;
        bit          ar_seen;
        logic [31:0] s_addr, sa;
        logic [2:0]  s_size;
        logic [3:0]  s_id;
        s_beats = 0; s_k = 0; stall_left = 0; ar_seen = 0;
        s_addr = '0; s_size = '0; s_id = '0;
        o_arready = 1'b1; o_rvalid = 1'b0; o_rlast = 1'b0;
        o_rdata = '0; o_rid = '0; o_rresp = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                s_beats = 0; ar_seen = 0; stall_left = 0;
                o_rvalid = 1'b0; o_rlast = 1'b0; o_arready = 1'b1;
            end else begin
                if (o_arvalid && !ar_seen) begin
                    ar_seen = 1;
                    stall_left = stall_cfg;
                end
                o_arready = (stall_left == 0);
                if (stall_left > 0) stall_left--;
                sa = beat_addr(s_addr, s_size, s_k);
                o_rvalid = (s_beats > 0);
                o_rlast  = (s_beats == 1);
                o_rdata  = {~sa, sa};
                o_rid    = s_id;
                o_rresp  = sa[4:3];
                if (o_rvalid && o_rready) begin
                    s_beats--;
                    s_k++;
                end
                if (o_arvalid && o_arready) begin
                    ar_log_addr.push_back(o_araddr);
                    ar_log_len.push_back(o_arlen);
                    ar_log_misc.push_back({o_arid, o_arsize, o_arburst, o_arextras});
                    s_addr  = o_araddr;
                    s_size  = o_arsize;
                    s_id    = o_arid;
                    s_beats = int'(o_arlen) + 1;
                    s_k     = 0;
                    ar_seen = 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Observe what the coming posedge will transfer, then move to the next negedge
    task automatic step();
        #2;
        cyc++;
        if (o_arvalid) begin
            if (prev_arv_wait && {o_araddr, o_arlen, o_arid, o_arsize, o_arburst, o_arextras} !== prev_pl[56:0])
                stable_err++;
            if (first_arv_cyc < 0) first_arv_cyc = cyc;
            if (!o_arready) stall_cnt++;
            prev_arv_wait = !o_arready;
            prev_pl = 64'({o_araddr, o_arlen, o_arid, o_arsize, o_arburst, o_arextras});
        end else begin
            prev_arv_wait = 0;
        end
        if (arvalid && arready) up_hs_cyc = cyc;
        if (rvalid && rready) begin
            beat_q.push_back(rdata);
            resp_q.push_back(rresp);
            last_rid = rid;
            if (rlast) begin
                rlast_cnt++;
                rlast_idx = beat_q.size();
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_book();
        beat_q.delete();
        resp_q.delete();
        rlast_cnt = 0; rlast_idx = 0; up_hs_cyc = -1; first_arv_cyc = -1;
        stable_err = 0; stall_cnt = 0; prev_arv_wait = 0; last_rid = '0;
        ar_base = ar_log_addr.size();
    endtask

    task automatic run_burst(input string tag, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id,
                             input logic [7:0] ext, input int stall, input bit toggle);
        bit done;
        clear_book();
        stall_cfg = stall;
        araddr = addr; arlen = len; arsize = size; arburst = burst; arid = id; arextras = ext;
        arvalid = 1'b1; rready = 1'b1;
        done = 0;
        for (int n = 0; n < 20 && !done; n++) begin
            step();
            done = (up_hs_cyc >= 0);
        end
        arvalid = 1'b0;
        done = 0;
        for (int n = 0; n < 3000 && !done; n++) begin
            if (toggle) rready = ~rready;
            step();
            done = (rlast_cnt > 0);
        end
        chk({tag, " completed"}, 64'(done), 64'd1);
        rready = 1'b1;
        step();
        step();
        stall_cfg = 0;
    endtask

    task automatic chk_npieces(input string tag, input int exp);
        chk({tag, " piece count"}, 64'(ar_log_addr.size() - ar_base), 64'(exp));
    endtask

    task automatic chk_piece(input string tag, input int idx, input logic [31:0] addr, input logic [7:0] len);
        logic [31:0] oa;
        logic [7:0]  ol;
        oa = 32'hDEAD_BEEF;
        ol = 8'hEE;
        if (ar_base + idx < ar_log_addr.size()) begin
            oa = ar_log_addr[ar_base + idx];
            ol = ar_log_len[ar_base + idx];
        end
        chk($sformatf("%s piece%0d addr", tag, idx), 64'(oa), 64'(addr));
        chk($sformatf("%s piece%0d len", tag, idx), 64'(ol), 64'(len));
    endtask

    task automatic chk_beats(input string tag, input logic [31:0] addr, input logic [2:0] size,
                             input logic [7:0] len, input logic [3:0] id);
        int          errs;
        logic [31:0] ea;
        errs = 0;
        for (int i = 0; i < beat_q.size() && i <= int'(len); i++) begin
            ea = beat_addr(addr, size, i);
            if (beat_q[i] !== {~ea, ea} || resp_q[i] !== ea[4:3]) errs++;
        end
        chk({tag, " beat count"}, 64'(beat_q.size()), 64'(int'(len) + 1));
        chk({tag, " rlast count"}, 64'(rlast_cnt), 64'd1);
        chk({tag, " rlast position"}, 64'(rlast_idx), 64'(int'(len) + 1));
        chk({tag, " data/resp order errors"}, 64'(errs), 64'd0);
        chk({tag, " rid"}, 64'(last_rid), 64'(id));
    endtask

    initial begin : main
        bit done;
        rst = 1'b1; arvalid = 1'b0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        arid = '0; arextras = '0; rready = 1'b1; cyc = 0;
        clear_book();
        repeat (2) @(negedge clk);
        #2;
        chk("reset arready", 64'(arready), 64'd0);
        chk("reset o_rready", 64'(o_rready), 64'd0);
        chk("reset o_arvalid", 64'(o_arvalid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("idle arready", 64'(arready), 64'd1);
        chk("idle o_arvalid", 64'(o_arvalid), 64'd0);
        chk("idle rvalid", 64'(rvalid), 64'd0);
        chk("idle o_araddr", 64'(o_araddr), 64'd0);
        chk("idle o_arlen", 64'(o_arlen), 64'd0);
        @(negedge clk);

        // Crossing at 0x1000: two pieces of two beats
        run_burst("cross", 32'h0000_0FF0, 8'd3, 3'd3, 2'b01, 4'h1, 8'h11, 0, 0);
        chk_npieces("cross", 2);
        chk_piece("cross", 0, 32'h0000_0FF0, 8'd1);
        chk_piece("cross", 1, 32'h0000_1000, 8'd1);
        chk_beats("cross", 32'h0000_0FF0, 3'd3, 8'd3, 4'h1);

        // 32KB burst of 128-byte beats: eight pages of 32 beats
        run_burst("big", 32'h0, 8'd255, 3'd7, 2'b01, 4'h2, 8'h22, 0, 0);
        chk_npieces("big", 8);
        for (int j = 0; j < 8; j++) chk_piece("big", j, 32'(j) << 12, 8'd31);
        chk_beats("big", 32'h0, 3'd7, 8'd255, 4'h2);

        // No crossing: payload identical, one-cycle AR latency
        run_burst("nocross", 32'h0000_0100, 8'd15, 3'd2, 2'b01, 4'h5, 8'hA5, 0, 0);
        chk_npieces("nocross", 1);
        chk_piece("nocross", 0, 32'h0000_0100, 8'd15);
        chk("nocross sideband", 64'(ar_log_misc[ar_base]), 64'({4'h5, 3'd2, 2'b01, 8'hA5}));
        chk("nocross AR latency", 64'(first_arv_cyc - up_hs_cyc), 64'd1);
        chk_beats("nocross", 32'h0000_0100, 3'd2, 8'd15, 4'h5);

        run_burst("wrap", 32'h0000_0FF8, 8'd3, 3'd3, 2'b10, 4'h6, 8'h5A, 0, 0);
        chk_npieces("wrap", 1);
        chk_piece("wrap", 0, 32'h0000_0FF8, 8'd3);
        chk("wrap sideband", 64'(ar_log_misc[ar_base]), 64'({4'h6, 3'd3, 2'b10, 8'h5A}));
        chk_beats("wrap", 32'h0000_0FF8, 3'd3, 8'd3, 4'h6);

        run_burst("fixed", 32'h0000_0FF8, 8'd3, 3'd3, 2'b00, 4'h7, 8'h3C, 0, 0);
        chk_npieces("fixed", 1);
        chk_piece("fixed", 0, 32'h0000_0FF8, 8'd3);
        chk("fixed sideband", 64'(ar_log_misc[ar_base]), 64'({4'h7, 3'd3, 2'b00, 8'h3C}));
        chk_beats("fixed", 32'h0000_0FF8, 3'd3, 8'd3, 4'h7);

        // Exactly one full page from an aligned start: no split
        run_burst("page", 32'h0000_2000, 8'd255, 3'd4, 2'b01, 4'h8, 8'h00, 0, 0);
        chk_npieces("page", 1);
        chk_piece("page", 0, 32'h0000_2000, 8'd255);
        chk_beats("page", 32'h0000_2000, 3'd4, 8'd255, 4'h8);

        // Address rolls over the top of the space
        run_burst("rollover", 32'hFFFF_FFF0, 8'd3, 3'd3, 2'b01, 4'h9, 8'h99, 0, 0);
        chk_npieces("rollover", 2);
        chk_piece("rollover", 0, 32'hFFFF_FFF0, 8'd1);
        chk_piece("rollover", 1, 32'h0000_0000, 8'd1);
        chk_beats("rollover", 32'hFFFF_FFF0, 3'd3, 8'd3, 4'h9);

        // Back-pressure on both sides
        run_burst("stall", 32'h0000_0FF0, 8'd3, 3'd3, 2'b01, 4'hA, 8'hAA, 5, 1);
        chk_npieces("stall", 2);
        chk("stall payload changes", 64'(stable_err), 64'd0);
        chk("stall cycles", 64'(stall_cnt), 64'd10);
        chk_piece("stall", 1, 32'h0000_1000, 8'd1);
        chk_beats("stall", 32'h0000_0FF0, 3'd3, 8'd3, 4'hA);

        // Reset while the second beat of the first piece is on offer
        clear_book();
        araddr = 32'h0000_0FF0; arlen = 8'd3; arsize = 3'd3; arburst = 2'b01; arid = 4'h3;
        arextras = 8'h33; arvalid = 1'b1; rready = 1'b1;
        done = 0;
        for (int n = 0; n < 20 && !done; n++) begin
            step();
            done = (up_hs_cyc >= 0);
        end
        arvalid = 1'b0;
        done = 0;
        for (int n = 0; n < 50 && !done; n++) begin
            step();
            done = (beat_q.size() >= 1);
        end
        chk("midrst first beat seen", 64'(done), 64'd1);
        rst = 1'b1;
        #2;
        chk("midrst o_rready in reset", 64'(o_rready), 64'd0);
        chk("midrst arready in reset", 64'(arready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("midrst arready after", 64'(arready), 64'd1);
        chk("midrst o_arvalid after", 64'(o_arvalid), 64'd0);
        chk("midrst rvalid after", 64'(rvalid), 64'd0);
        @(negedge clk);
        run_burst("postrst", 32'h0000_0100, 8'd15, 3'd2, 2'b01, 4'h4, 8'h44, 0, 0);
        chk_npieces("postrst", 1);
        chk_piece("postrst", 0, 32'h0000_0100, 8'd15);
        chk_beats("postrst", 32'h0000_0100, 3'd2, 8'd15, 4'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
